// File: rtl/regfile_pkg.sv
// Shared sizing and constants for the 8 x 16-bit register file.
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  localparam logic [ADDR_W-1:0] REG_ZERO  = '0;
  localparam logic [DATA_W-1:0] ZERO_WORD = 16'h0000;

endpackage

// File: rtl/reg16_en.sv
// One DATA_W-wide storage register with asynchronous active-low clear
// and a synchronous load enable.
module reg16_en
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Clear immediately on reset; otherwise load d on an enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= ZERO_WORD;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_16.sv
// 8 x 16-bit register file: two combinational read ports and one synchronous
// write port. r0 is a constant zero, not a flop.
// Optional build macro REGFILE_BYPASS_EN adds a write-through path, so a read
// of the index being written returns wdata in the same cycle.
module regfile_16
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [NUM_REGS-1:1] wr_sel;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  assign regs[0] = ZERO_WORD;

  // One-hot write decode. There is no select for r0, so writes to it are dropped.
  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      wr_sel[i] = we && (waddr == ADDR_W'(i));
    end
  end

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    reg16_en u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (wr_sel[g]),
      .d     (wdata),
      .q     (regs[g])
    );
  end

`ifdef REGFILE_BYPASS_EN
  // Read muxes with write-through forwarding. r0 is never forwarded.
  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    if (we && (waddr != REG_ZERO) && (raddr1 == waddr)) rdata1 = wdata;
    if (we && (waddr != REG_ZERO) && (raddr2 == waddr)) rdata2 = wdata;
  end
`else
  // Plain read muxes. A same-cycle read of the written index returns the old value.
  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
  end
`endif

endmodule
